// File: rtl/uart_i2c_bridge.sv
// rtl/uart_i2c_bridge.sv - UART framed command to I2C master command/data bridge
module uart_i2c_bridge #(
    parameter int MAX_LEN        = 16,
    parameter int REG_ADDR_BYTES = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_uart_tdata,
    input  logic       s_uart_tvalid,
    output logic       s_uart_tready,
    output logic [7:0] m_uart_tdata,
    output logic       m_uart_tvalid,
    input  logic       m_uart_tready,
    output logic [6:0] m_cmd_address,
    output logic       m_cmd_start,
    output logic       m_cmd_read,
    output logic       m_cmd_write_multiple,
    output logic       m_cmd_stop,
    output logic       m_cmd_valid,
    input  logic       m_cmd_ready,
    output logic [7:0] m_data_tdata,
    output logic       m_data_tvalid,
    input  logic       m_data_tready,
    output logic       m_data_tlast,
    input  logic [7:0] s_data_tdata,
    input  logic       s_data_tvalid,
    output logic       s_data_tready,
    input  logic       s_data_tlast,
    input  logic       missed_ack,
    output logic       busy,
    output logic       irq
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = (CW > 2) ? CW : 2;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IW-1:0] ONE      = IW'(1);
    localparam logic [1:0]    RB_LAST  = 2'(REG_ADDR_BYTES - 1);
    localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);

    typedef enum logic [3:0] {
        IDLE, GET_LEN, GET_REG, GET_DATA, WR_CMD, WR_DATA, RA_CMD,
        RA_DATA, RD_CMD, RD_DATA, ABORT, STATUS
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [IW-1:0] len_q, len_d, idx_q, idx_d;
    logic [15:0]   reg_q, reg_d;
    logic [1:0]    rb_q, rb_d;
    logic [31:0]   timer_q, timer_d;
    logic [7:0]    code_q, code_d;
    logic          irq_q, irq_d;
    logic          mem_we;
    logic [7:0]    mem [MAX_LEN];
    logic [7:0]    reg_byte;
    logic          unused_tlast;

    assign unused_tlast = s_data_tlast;
    assign reg_byte = (REG_ADDR_BYTES == 2 && rb_q == 2'd0) ? reg_q[15:8] : reg_q[7:0];

    always_comb begin
        state_d = state_q; addr_d = addr_q; rw_d = rw_q; len_d = len_q; idx_d = idx_q;
        reg_d = reg_q; rb_d = rb_q; timer_d = timer_q; code_d = code_q; irq_d = 1'b0;
        mem_we = 1'b0;
        s_uart_tready = 1'b0; m_uart_tdata = 8'h00; m_uart_tvalid = 1'b0;
        m_cmd_address = 7'h00; m_cmd_start = 1'b0; m_cmd_read = 1'b0;
        m_cmd_write_multiple = 1'b0; m_cmd_stop = 1'b0; m_cmd_valid = 1'b0;
        m_data_tdata = 8'h00; m_data_tvalid = 1'b0; m_data_tlast = 1'b0;
        s_data_tready = 1'b0; busy = 1'b0; irq = 1'b0;
        if (!rst) begin
            busy = (state_q != IDLE);
            irq  = irq_q;
            case (state_q)
                IDLE: begin
                    s_uart_tready = 1'b1;
                    timer_d = 32'd0;
                    if (s_uart_tvalid) begin
                        addr_d = s_uart_tdata[7:1]; rw_d = s_uart_tdata[0]; state_d = GET_LEN;
                    end
                end
                GET_LEN: begin
                    s_uart_tready = 1'b1;
                    if (s_uart_tvalid) begin
                        if (s_uart_tdata == 8'h00 || s_uart_tdata > MAX_B) begin
                            code_d = 8'h03; state_d = STATUS;
                        end else begin
                            len_d = s_uart_tdata[IW-1:0]; rb_d = 2'd0; state_d = GET_REG;
                        end
                    end
                end
                GET_REG: begin
                    s_uart_tready = 1'b1;
                    if (s_uart_tvalid) begin
                        reg_d = {reg_q[7:0], s_uart_tdata};
                        rb_d  = rb_q + 2'd1;
                        if (rb_q == RB_LAST) begin
                            idx_d = '0; state_d = rw_q ? RA_CMD : GET_DATA;
                        end
                    end
                end
                GET_DATA: begin
                    s_uart_tready = 1'b1;
                    if (s_uart_tvalid) begin
                        mem_we = 1'b1; idx_d = idx_q + ONE;
                        if (idx_q == len_q - ONE) begin
                            idx_d = '0; state_d = WR_CMD;
                        end
                    end
                end
                WR_CMD, RA_CMD: begin
                    m_cmd_valid = 1'b1; m_cmd_address = addr_q; m_cmd_start = 1'b1;
                    m_cmd_write_multiple = 1'b1; m_cmd_stop = (state_q == WR_CMD);
                    if (m_cmd_ready) begin
                        rb_d = 2'd0; idx_d = '0;
                        state_d = (state_q == WR_CMD) ? WR_DATA : RA_DATA;
                    end
                end
                WR_DATA: begin
                    m_data_tvalid = 1'b1;
                    if (rb_q <= RB_LAST) begin
                        m_data_tdata = reg_byte;
                        if (m_data_tready) rb_d = rb_q + 2'd1;
                    end else begin
                        m_data_tdata = mem[idx_q[AW-1:0]];
                        m_data_tlast = (idx_q == len_q - ONE);
                        if (m_data_tready) begin
                            idx_d = idx_q + ONE;
                            if (m_data_tlast) begin
                                code_d = 8'h00; state_d = STATUS;
                            end
                        end
                    end
                end
                RA_DATA: begin
                    m_data_tvalid = 1'b1; m_data_tdata = reg_byte;
                    m_data_tlast  = (rb_q == RB_LAST);
                    if (m_data_tready) begin
                        rb_d = rb_q + 2'd1;
                        if (m_data_tlast) state_d = RD_CMD;
                    end
                end
                RD_CMD: begin
                    // one single-byte read per command; start opens, stop closes the burst
                    m_cmd_valid = 1'b1; m_cmd_address = addr_q; m_cmd_read = 1'b1;
                    m_cmd_start = (idx_q == '0); m_cmd_stop = (idx_q == len_q - ONE);
                    if (m_cmd_ready) state_d = RD_DATA;
                end
                RD_DATA: begin
                    s_data_tready = m_uart_tready;
                    m_uart_tvalid = s_data_tvalid; m_uart_tdata = s_data_tdata;
                    if (s_data_tvalid && m_uart_tready) begin
                        idx_d = idx_q + ONE;
                        if (idx_q == len_q - ONE) begin
                            code_d = 8'h00; state_d = STATUS;
                        end else begin
                            state_d = RD_CMD;
                        end
                    end
                end
                ABORT: begin
                    m_cmd_valid = 1'b1; m_cmd_address = addr_q; m_cmd_stop = 1'b1;
                    if (m_cmd_ready) begin
                        code_d = 8'h01; state_d = STATUS;
                    end
                end
                STATUS: begin
                    m_uart_tvalid = 1'b1; m_uart_tdata = code_q;
                    if (m_uart_tready) begin
                        irq_d = 1'b1; idx_d = '0; state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // a byte arriving on the deadline cycle wins over the timeout
            if (state_q inside {GET_LEN, GET_REG, GET_DATA}) begin
                if (s_uart_tvalid) timer_d = 32'd0;
                else if (timer_q == TMO_LAST) begin
                    code_d = 8'h02; idx_d = '0; state_d = STATUS;
                end else timer_d = timer_q + 32'd1;
            end
            if (missed_ack && state_q inside {WR_CMD, WR_DATA, RA_CMD, RA_DATA, RD_CMD, RD_DATA})
                state_d = ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE; addr_q <= '0; rw_q <= 1'b0; len_q <= '0; idx_q <= '0;
            reg_q <= '0; rb_q <= '0; timer_q <= '0; code_q <= '0; irq_q <= 1'b0;
        end else begin
            state_q <= state_d; addr_q <= addr_d; rw_q <= rw_d; len_q <= len_d; idx_q <= idx_d;
            reg_q <= reg_d; rb_q <= rb_d; timer_q <= timer_d; code_q <= code_d; irq_q <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q[AW-1:0]] <= s_uart_tdata;
    end
endmodule

// File: doc/uart_i2c_bridge.md
UART_I2C_BRIDGE -- requirements
Module: uart_i2c_bridge

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: max data bytes per transaction, 1..255.
REQ-002 SHALL have parameter REG_ADDR_BYTES, default 1: register-address bytes sent MSB first, 1 or 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: allowed idle gap between UART bytes within one frame.
REQ-004 SHALL have one clock and synchronous active-high reset: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-005 SHALL have s_uart_tdata/tvalid/tready: in 8 / in 1 / out 1, bytes from UART receiver.
REQ-006 SHALL have m_uart_tdata/tvalid/tready: out 8 / out 1 / in 1, bytes to UART transmitter.
REQ-007 SHALL have m_cmd_address out 7, m_cmd_start, m_cmd_read, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid out 1 each, and m_cmd_ready in 1 (I2C master command).
REQ-008 SHALL have m_data_tdata out 8, m_data_tvalid out 1, m_data_tready in 1, m_data_tlast out 1 (write data to I2C).
REQ-009 SHALL have s_data_tdata in 8, s_data_tvalid in 1, s_data_tready out 1, s_data_tlast in 1 (read data from I2C).
REQ-010 SHALL have missed_ack in 1 (I2C NACK pulse), busy out 1 (not IDLE), irq out 1 (one-cycle done pulse).

Function
REQ-011 SHALL parse UART frames: byte0 {addr[6:0], rw}; byte1 length N; next REG_ADDR_BYTES register-address bytes; if rw=0, N write data bytes.
REQ-012 SHALL use states IDLE, GET_LEN, GET_REG, GET_DATA, WR_CMD, WR_DATA, RA_CMD, RA_DATA, RD_CMD, RD_DATA, ABORT, STATUS.
REQ-013 SHALL hold s_uart_tready=1 only in IDLE, GET_LEN, GET_REG and GET_DATA; bytes transfer on tvalid&&tready.
REQ-014 SHALL, on N=0 or N>MAX_LEN in GET_LEN, go to STATUS with code 0x03 and accept no further bytes of that frame.
REQ-015 SHALL buffer write data in a MAX_LEN-deep FIFO and issue no I2C command until all N bytes are received.
REQ-016 SHALL, in WR_CMD, assert m_cmd_valid with start=1, write_multiple=1, stop=1, and hold all m_cmd_* stable until m_cmd_ready.
REQ-017 SHALL, in WR_DATA, stream register-address bytes then N FIFO bytes, with m_data_tlast=1 only on the final byte.
REQ-018 SHALL, for reads, issue write_multiple with start=1, stop=0 (RA_CMD), stream register-address bytes with tlast on the last (RA_DATA), then issue N read commands (RD_CMD).
REQ-019 SHALL set start=1 on the first read command only and stop=1 on the N-th read command only.
REQ-020 SHALL, in RD_DATA, hold s_data_tready=m_uart_tready and forward each read byte to m_uart unchanged, one byte per read command.
REQ-021 SHALL count gaps between frame bytes in GET_* states and, at TIMEOUT_CYCLES, discard the partial frame, flush the FIFO, and go to STATUS with code 0x02.
REQ-022 SHALL, on missed_ack in any WR_*/RA_*/RD_* state, enter ABORT, drop remaining data, issue one command with stop=1 and all other flags 0, then go to STATUS with code 0x01.
REQ-023 SHALL, on successful completion, go to STATUS with code 0x00.
REQ-024 SHALL, in STATUS, present the code on m_uart_tdata with tvalid=1; on handshake, pulse irq for one cycle and return to IDLE.
REQ-025 SHALL let missed_ack take priority over any same-cycle data handshake; that byte is counted, but the transaction aborts.
REQ-026 SHALL let a timeout and a byte arriving in the same cycle resolve in favour of the byte (counter resets).
REQ-027 SHALL track byte counts with width clog2(MAX_LEN+1) and never wrap.

Reset
REQ-028 SHALL, on rst, go to IDLE, empty the FIFO, clear counters, and drive all valid outputs, s_uart_tready, s_data_tready, m_data_tlast, busy and irq to 0, and address/data outputs to 0.
REQ-029 SHALL, on rst mid-transaction, abandon it in the next cycle with no STATUS byte; s_uart_tready returns to 1 one cycle after rst deasserts.

Verification
REQ-030 SHALL verify a write: UART 0x9A,0x02,0x3B,0x11,0x22 -> one cmd addr=0x4D, start/write_multiple/stop; data 0x3B,0x11,0x22 with tlast on 0x22; status 0x00; irq pulse.
REQ-031 SHALL verify a read: UART 0x9B,0x03,0x3B with I2C returning 0xA1,0xA2,0xA3 -> write_multiple stop=0 plus data 0x3B/tlast; three read cmds, start on the first, stop on the third; UART out A1,A2,A3,0x00.
REQ-032 SHALL verify a NACK: missed_ack during the data 0x11 in REQ-030 -> a stop-only command, then UART 0x01, no further m_data.
REQ-033 SHALL verify bad length: 0x9A,0x00 and 0x9A,MAX_LEN+1 -> UART 0x03, no I2C command.
REQ-034 SHALL verify timeout: 0x9A,0x02 then silence for TIMEOUT_CYCLES -> UART 0x02; the next valid frame completes normally.
REQ-035 SHALL verify mid-transaction reset: rst during RD_DATA -> outputs per REQ-028, no status byte, and a subsequent write succeeds.
